seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the 4-digit multiplexed seven-segment display interface driven by the reaction-speed tester top: AN, leds, point.
- Watches the scanned anode/segment lines, waits for each digit's pattern to settle, and decodes it back to a 4-bit digit code.
- Assembles complete 4-digit frames and reports them with a one-cycle strobe.
- Used in benches and on-board self-check to read the displayed reaction time as numbers.

Parameters:
- SETTLE_CYC, 4, consecutive identical samples (same AN and same segments) required before a digit is captured; legal range 1..255.
- TIMEOUT_CYC, 1000, cycles with no digit capture before stale asserts and the partial frame is discarded; legal range 2..2^20-1.

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- AN  input  4  anode selects, active-low; AN[0] is the rightmost digit.
- leds  input  7  segments, active-low; leds[0]=a, leds[1]=b, ..., leds[6]=g.
- point  input  1  decimal point, active-low.
- digits  output  16  captured frame; digits[4i+3:4i] is the code for digit i.
- dp  output  4  dp[i]=1 when the point was lit on digit i.
- blank  output  4  blank[i]=1 when digit i had all segments off; its code is 4'h0.
- err  output  1  at least one digit in the frame had an undecodable pattern.
- frame_valid  output  1  one-cycle pulse when digits/dp/blank/err update.
- stale  output  1  no capture for TIMEOUT_CYC cycles.

Behaviour:
- Reset: all outputs and internal state return to 0 (digits=16'h0, dp=0, blank=0, err=0, frame_valid=0, stale=0). Reset is asynchronous and takes effect mid-frame: the partial frame is dropped and settle/timeout counters clear.
- Input stage: AN, leds and point are registered once. All decisions use the registered copies, so latency is 1 cycle plus the settle time.
- Select validity: exactly one AN bit low is a valid select. AN=4'hF or more than one bit low is ignored and resets the settle counter.
- Settle counter: counts consecutive cycles with a valid select and an unchanged {AN, leds, point}; any change reloads it to 1.
- Capture: when the count reaches SETTLE_CYC, the digit is captured exactly once per dwell. Re-arming requires a change of AN or segments.
- Decode (active-low patterns, g..a order):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 1111111 sets blank with code 0.
  - Any other pattern gives code 4'hF and sets the digit's error bit.
- Frame assembly:
  - Each capture writes the digit's code/dp/blank/error into a shadow slot and sets mask[i].
  - Re-capturing an already-masked digit before frame completion overwrites its slot; the newest data wins.
  - When mask==4'hF after a capture, the shadow is copied to the outputs and frame_valid pulses in the following cycle. err is the OR of the four error bits. mask then clears.
- State machine, 3 states:
  - IDLE: mask empty. The first capture moves to COLLECT.
  - COLLECT: a capture that completes the mask moves to EMIT.
  - EMIT: 1 cycle; frame_valid=1, outputs update; returns to IDLE.
  - Timeout: in IDLE or COLLECT, if TIMEOUT_CYC cycles pass with no capture, go to IDLE, clear mask, and set stale.
- Timeout counter: reset by every capture. It saturates and does not wrap.
- stale: clears on the next capture. Outputs hold their last frame while stale.
- Same-cycle capture and timeout: the capture wins; no stale is raised.

Optional Feature:
- Macro: SEG7_CAPTURE_HEX_EN.
- Defined: patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 decode to 4'hA..4'hF without error.
- Undefined: those patterns are undecodable, giving code 4'hF and setting err.
- All other behaviour is identical either way.

Test Plan:
- Reset low for 100 ns, then high → all outputs 0, stale=0, no frame_valid.
- Scan "0235" (AN 1110/1101/1011/0111 carry 5,3,2,0), 8 cycles per digit, point lit on digit 2 → one frame_valid, digits=16'h0235, dp=4'b0100, blank=0, err=0.
- Same scan, but each AN step first shows 2 cycles of the previous segment pattern (ghost) → still digits=16'h0235, exactly one frame_valid per full scan.
- Digit 1 shows 0000110 ("E"), others "1" → without SEG7_CAPTURE_HEX_EN: err=1, digits=16'h11F1; with it: err=0, digits=16'h11E1.
- Scan stops after two digits (AN held at 4'hF) → stale=1 at capture+TIMEOUT_CYC, no frame_valid, outputs keep the previous frame; resuming the full scan clears stale and emits a new frame.
- reset_n pulsed low mid-scan after 3 digits → outputs 0 immediately; the next complete 4-digit scan produces a frame with no leftover data.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a scanned 4-digit seven-segment display back into digit frames
// Ports: sysclk/reset_n clock and async active-low reset; AN/leds/point scanned display lines (all active-low);
//        digits/dp/blank/err last complete frame; frame_valid one-cycle update strobe; stale no capture for TIMEOUT_CYC.
// Optional: define SEG7_CAPTURE_HEX_EN to decode the letters A..F without error.
module seg7_scan_capture #(
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic [3:0]  AN,
  input  logic [6:0]  leds,
  input  logic        point,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        err,
  output logic        frame_valid,
  output logic        stale
);
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t state, state_n;
  logic [3:0] an_r, mask, mask_n, sh_dp, sh_dp_n, sh_blank, sh_blank_n, sh_err, sh_err_n, dec_code;
  logic [6:0] seg_r;
  logic pt_r, valid, changed, capture, timeout, dec_err;
  logic [11:0] prev_r;
  logic [7:0] cnt, cnt_n;
  logic [19:0] tcnt, tcnt_n;
  logic [15:0] sh_code, sh_code_n;
  logic [1:0] idx;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b1111111: return 5'h00;
`ifdef SEG7_CAPTURE_HEX_EN
      7'b0001000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
`endif
      default:    return 5'h1F;
    endcase
  endfunction
  assign valid = $onehot(~an_r);
  assign changed = {an_r, seg_r, pt_r} != prev_r;
  assign idx = {~an_r[3] | ~an_r[2], ~an_r[3] | ~an_r[1]};
  assign {dec_err, dec_code} = decode(seg_r);
  assign cnt_n = !valid ? 8'd0 : changed ? 8'd1 : (cnt < 8'(SETTLE_CYC)) ? cnt + 8'd1 : cnt;
  assign capture = valid && cnt_n == 8'(SETTLE_CYC) && (changed || cnt != 8'(SETTLE_CYC));
  assign tcnt_n = capture ? 20'd0 : (tcnt < 20'(TIMEOUT_CYC)) ? tcnt + 20'd1 : tcnt;
  assign timeout = !capture && tcnt_n == 20'(TIMEOUT_CYC) && tcnt != 20'(TIMEOUT_CYC);
  assign frame_valid = state == EMIT;
  always_comb begin
    state_n = state;
    mask_n = mask;
    sh_code_n = sh_code;
    sh_dp_n = sh_dp;
    sh_blank_n = sh_blank;
    sh_err_n = sh_err;
    if (capture) begin
      mask_n[idx] = 1'b1;
      sh_code_n[{idx, 2'b00} +: 4] = dec_code;
      sh_dp_n[idx] = ~pt_r;
      sh_blank_n[idx] = seg_r == 7'h7F;
      sh_err_n[idx] = dec_err;
      state_n = &mask_n ? EMIT : COLLECT;
      if (&mask_n) mask_n = 4'h0;
    end else if (timeout) begin
      state_n = IDLE;
      mask_n = 4'h0;
    end else if (state == EMIT) state_n = IDLE;
  end
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      {an_r, seg_r, pt_r, prev_r} <= '0;
      cnt <= '0;
      tcnt <= '0;
      state <= IDLE;
      mask <= '0;
      {sh_code, sh_dp, sh_blank, sh_err} <= '0;
      {digits, dp, blank, err, stale} <= '0;
    end else begin
      {an_r, seg_r, pt_r} <= {AN, leds, point};
      prev_r <= {an_r, seg_r, pt_r};
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      state <= state_n;
      mask <= mask_n;
      {sh_code, sh_dp, sh_blank, sh_err} <= {sh_code_n, sh_dp_n, sh_blank_n, sh_err_n};
      if (state_n == EMIT) {digits, dp, blank, err} <= {sh_code_n, sh_dp_n, sh_blank_n, |sh_err_n};
      stale <= capture ? 1'b0 : timeout ? 1'b1 : stale;
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench for the seven-segment scan capture block
module tb_seg7_scan_capture;
  localparam int T = 50;
  logic sysclk = 0, reset_n = 1, point = 1, err, frame_valid, stale;
  logic [3:0] AN = 4'hF, dp, blank;
  logic [6:0] leds = 7'h7F, prev_seg = 7'h7F;
  logic prev_pt = 1;
  logic [15:0] digits;
  logic [24:0] exp_q[$], got_q[$], e, g, last_frame;
  int checks = 0, passed = 0;

  seg7_scan_capture #(.SETTLE_CYC(4), .TIMEOUT_CYC(T)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .AN(AN), .leds(leds), .point(point),
    .digits(digits), .dp(dp), .blank(blank), .err(err), .frame_valid(frame_valid), .stale(stale)
  );

  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) if (frame_valid) got_q.push_back({digits, dp, blank, err});

  function automatic logic [6:0] seg(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] pats4(input logic [15:0] c);
    return {seg(c[15:12]), seg(c[11:8]), seg(c[7:4]), seg(c[3:0])};
  endfunction

  task automatic scan(input logic [27:0] pats, input logic [3:0] pts, input int start, input int n, input bit ghost);
    for (int k = 0; k < n; k++) begin
      int i = (start + k) % 4;
      if (ghost) begin
        AN = ~(4'b0001 << i); leds = prev_seg; point = prev_pt;
        repeat (2) @(negedge sysclk);
      end
      AN = ~(4'b0001 << i); leds = pats[7*i +: 7]; point = ~pts[i];
      prev_seg = leds; prev_pt = point;
      repeat (8) @(negedge sysclk);
    end
    AN = 4'hF; leds = 7'h7F; point = 1;
  endtask

  task automatic test_reset;
    #1 reset_n = 0;
    #100 reset_n = 1;
    @(negedge sysclk);
    checks++; if ({digits, dp, blank, err} !== 25'h0) $display("FAIL reset_outputs got %h want 0", {digits, dp, blank, err}); else passed++;
    checks++; if (stale !== 1'b0) $display("FAIL reset_stale got %b want 0", stale); else passed++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid got %b want 0", frame_valid); else passed++;
  endtask

  task automatic test_scan;
    exp_q.push_back({16'h0235, 4'b0100, 4'b0000, 1'b0});
    scan(pats4(16'h0235), 4'b0100, 0, 4, 0);
    repeat (4) @(negedge sysclk);
    checks++; if (stale !== 1'b0) $display("FAIL scan_stale got %b want 0", stale); else passed++;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL scan_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL scan_frame got %h want %h", g, e); else passed++;
      last_frame = e;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_ghost;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({16'h0235, 4'b0100, 4'b0000, 1'b0});
      scan(pats4(16'h0235), 4'b0100, 0, 4, 1);
    end
    repeat (4) @(negedge sysclk);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL ghost_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL ghost_frame got %h want %h", g, e); else passed++;
      last_frame = e;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_blank;
    exp_q.push_back({16'h0407, 4'b0001, 4'b1000, 1'b0});
    scan({7'h7F, seg(4'd4), seg(4'd0), seg(4'd7)}, 4'b0001, 0, 4, 0);
    repeat (4) @(negedge sysclk);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL blank_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL blank_frame got %h want %h", g, e); else passed++;
      last_frame = e;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_hex;
`ifdef SEG7_CAPTURE_HEX_EN
    exp_q.push_back({16'h11E1, 4'b0000, 4'b0000, 1'b0});
`else
    exp_q.push_back({16'h11F1, 4'b0000, 4'b0000, 1'b1});
`endif
    scan({seg(4'd1), seg(4'd1), 7'b0000110, seg(4'd1)}, 4'b0000, 0, 4, 0);
    repeat (4) @(negedge sysclk);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL hex_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL hex_frame got %h want %h", g, e); else passed++;
      last_frame = e;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall;
    scan(pats4(16'h9876), 4'b0000, 0, 2, 0);
    repeat (T - 6) @(negedge sysclk);
    checks++; if (stale !== 1'b0) $display("FAIL stall_early_stale got %b want 0", stale); else passed++;
    repeat (6) @(negedge sysclk);
    checks++; if (stale !== 1'b1) $display("FAIL stall_stale got %b want 1", stale); else passed++;
    checks++; if (got_q.size() !== 0) $display("FAIL stall_no_frame got %0d want 0", got_q.size()); else passed++;
    checks++; if ({digits, dp, blank, err} !== last_frame) $display("FAIL stall_hold got %h want %h", {digits, dp, blank, err}, last_frame); else passed++;
    exp_q.push_back({16'h9876, 4'b1000, 4'b0000, 1'b0});
    scan(pats4(16'h9876), 4'b1000, 0, 4, 0);
    checks++; if (stale !== 1'b0) $display("FAIL resume_stale got %b want 0", stale); else passed++;
    repeat (4) @(negedge sysclk);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL resume_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL resume_frame got %h want %h", g, e); else passed++;
      last_frame = e;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid;
    scan(pats4(16'h8888), 4'b1111, 0, 3, 0);
    #2 reset_n = 0;
    #1;
    checks++; if ({digits, dp, blank, err} !== 25'h0) $display("FAIL midreset_outputs got %h want 0", {digits, dp, blank, err}); else passed++;
    checks++; if ({stale, frame_valid} !== 2'b00) $display("FAIL midreset_flags got %b want 00", {stale, frame_valid}); else passed++;
    #20 reset_n = 1;
    @(negedge sysclk);
    exp_q.push_back({16'h4679, 4'b0000, 4'b0000, 1'b0});
    scan(pats4(16'h4679), 4'b0000, 3, 4, 0);
    repeat (4) @(negedge sysclk);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL midreset_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL midreset_frame got %h want %h", g, e); else passed++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset;
    test_scan;
    test_ghost;
    test_blank;
    test_hex;
    test_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
